motor_pwm_ctrl: RTL and testbench
=================================

Name: motor_pwm_ctrl

Overview:
- Downstream consumer of the XBee frame parser's four motor command bytes and its frame-complete level.
- Converts each byte into a sign-magnitude PWM and direction pair for one H-bridge channel.
- Updates are synchronised to PWM period boundaries, and a direction reversal inserts a dead period.
- A link watchdog stops all motors when frames stop arriving.

Parameters:
- PRESCALE, 391: system clocks per PWM tick; 50 MHz / 391 / 127 ≈ 1 kHz PWM.
- WDOG_PERIODS, 200: PWM periods without a new frame before timeout.
- RAMP_STEP, 4: maximum magnitude change per period; used only with MOTOR_PWM_RAMP_EN.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rdone  in  1  parser frame-complete level; a rising edge marks a new command set
- motor1..motor4  in  8 each  command bytes; bit7 = direction (1 = reverse), bits6:0 = magnitude 0..127
- pwm  out  4  PWM per channel; bit0 = motor1
- dir  out  4  direction per channel
- fault  out  1  watchdog timeout flag
- pending  out  1  a captured command is waiting for the next period boundary

Behaviour:
Reset and timing base:
- Reset: pwm=0, dir=0, fault=0, pending=0; prescaler, pwm_cnt and watchdog counters = 0; active and shadow magnitudes = 0; channel FSMs = IDLE.
- Prescaler counts 0..PRESCALE-1. The tick is asserted for one clock when the count equals PRESCALE-1, and the count then wraps to 0.
- pwm_cnt advances on tick over 0..126 and wraps to 0.
- Boundary: tick && pwm_cnt==126.
- Channel output: pwm = (pwm_cnt < active_mag). Magnitude 0 gives constant low; 127 gives constant high.

Capture and load:
- rdone is registered once, and rise = rdone & ~rdone_q.
- On rise: all four bytes are captured into the shadow registers, pending is set, the watchdog is cleared and fault is cleared.
- On boundary with pending=1: each channel loads its shadow value, and pending clears.
- Latency: pwm reflects a new magnitude starting on the first pwm_cnt=0 after the boundary following rise+1 clock.
- Rise and boundary in the same clock: the boundary loads the old shadow, and the new capture stays pending for the next boundary. pending stays 1.

Channel FSM (per motor): IDLE, RUN, DEAD.
- IDLE: the output magnitude is 0. On load with magnitude != 0, the channel goes to RUN with dir = new dir.
- RUN, load with the same dir: the magnitude is updated.
- RUN, load with magnitude 0: the channel goes to IDLE and dir holds.
- RUN, load with a different dir and magnitude != 0: the channel goes to DEAD. active_mag=0 for one full period, and the target is held.
- DEAD, at the next boundary: the channel sets dir = target dir, loads the target magnitude and goes to RUN.
- DEAD, when a new load arrives: it replaces the target, and the dead period still completes.
- dir changes only at boundaries, never while pwm is high.

Watchdog:
- The counter increments on each boundary.
- When it reaches WDOG_PERIODS: fault is set, all shadows are forced to magnitude 0 with pending=1, and the counter saturates.
- Rise and expiry in the same clock: rise wins. The counter clears and fault stays 0.
- fault clears only on the next rise.
- Reset mid-period: all outputs drop low in the next clock, with no completion of the current period.

Optional Feature:
- Macro name: MOTOR_PWM_RAMP_EN.
- When defined: in RUN, active_mag moves toward the target by at most RAMP_STEP per boundary, saturating at the target. The DEAD exit starts from magnitude 0 and ramps. A watchdog stop ramps down as well.
- When undefined: loads are immediate as described above. The RAMP_STEP parameter is ignored.

Decomposition:
- Shared package motor_pkg: channel state encodings (IDLE/RUN/DEAD), MAG_W=7, PWM_TOP=126, and the command-byte field positions (DIR_BIT=7).
- Sub-module motor_pwm_channel: per-channel FSM, ramp logic and comparator. It is instantiated four times by the top, which owns the prescaler, pwm_cnt, edge detect, shadows and watchdog.

Test Plan:
1. Reset, then rdone rise with motor1=0x40 (fwd, 64) → after the boundary: pwm[0] high for 64 of 127 ticks per period, dir[0]=0; the other channels stay low.
2. motor2=0x7F, then 0x00 → pwm[1] is constant high for the full period, then constant low from the next boundary; the FSM goes to IDLE.
3. motor3=0x20, then 0xA0 (reverse, 32) → one full period of pwm[2]=0 with dir[2] still 0; dir[2]=1 at the following boundary; then 32/127 duty.
4. Rise forced in the same clock as a boundary with a new value → the old shadow is applied, pending stays 1, and the new value applies one period later.
5. No frames for WDOG_PERIODS=200 periods while running at 0x50 → fault=1 and pwm=0 after the next boundary. A later rise with 0x30 → fault=0, duty 48/127.
6. With MOTOR_PWM_RAMP_EN and RAMP_STEP=4, command 0 to 0x10 → active magnitude 4, 8, 12, 16 on successive boundaries.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared encodings for the motor PWM controller: channel states, magnitude width,
// PWM counter top and command-byte field positions.
package motor_pkg;

    localparam int MAG_W   = 7;
    localparam int MAG_MAX = 127;
    localparam int DIR_BIT = 7;
    localparam logic [MAG_W-1:0] PWM_TOP = 7'd126;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_RUN  = 2'd1,
        CH_DEAD = 2'd2
    } ch_state_e;

    // Move cur toward tgt by at most step; a step of MAG_MAX or more lands on tgt.
    function automatic logic [MAG_W-1:0] mag_step(input logic [MAG_W-1:0] cur,
                                                  input logic [MAG_W-1:0] tgt,
                                                  input int step);
        int diff;
        diff = int'(tgt) - int'(cur);
        if (diff > step) return cur + MAG_W'(step);
        else if (diff < -step) return cur - MAG_W'(step);
        return tgt;
    endfunction

endpackage

// File: rtl/motor_pwm_channel.sv
// One H-bridge channel: state | meaning
//   CH_IDLE | magnitude 0, dir held          CH_RUN | driving toward target magnitude
//   CH_DEAD | one full period at 0 before a direction reversal takes effect
module motor_pwm_channel
    import motor_pkg::*;
#(
    parameter int STEP = MAG_MAX
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             boundary,
    input  logic             load,
    input  logic [7:0]       cmd,
    input  logic [MAG_W-1:0] pwm_cnt,
    output logic             pwm,
    output logic             dir
);

    ch_state_e        state_q, state_d;
    logic [MAG_W-1:0] mag_q, mag_d;
    logic             dir_q, dir_d;
    logic [7:0]       tgt_q, tgt_d;
    logic [MAG_W-1:0] cmd_mag;
    logic             cmd_dir;
    logic [7:0]       tgt_eff;
    logic             reversal;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= CH_IDLE;
            mag_q   <= '0;
            dir_q   <= 1'b0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            dir_q   <= dir_d;
            tgt_q   <= tgt_d;
        end
    end

    always_comb begin
        cmd_mag  = cmd[MAG_W-1:0];
        cmd_dir  = cmd[DIR_BIT];
        tgt_eff  = load ? cmd : tgt_q;
        reversal = load && (cmd_mag != '0) && (cmd_dir != dir_q);
    end

    always_comb begin
        state_d = state_q;
        if (boundary) begin
            unique case (state_q)
                CH_IDLE: if (load && cmd_mag != '0) state_d = CH_RUN;
                CH_RUN:  if (reversal) state_d = CH_DEAD;
                         else if (mag_d == '0 && tgt_d[MAG_W-1:0] == '0) state_d = CH_IDLE;
                CH_DEAD: state_d = (tgt_eff[MAG_W-1:0] != '0) ? CH_RUN : CH_IDLE;
                default: state_d = CH_IDLE;
            endcase
        end
    end

    // A load during the dead period only replaces the target; the exit still waits for this boundary.
    always_comb begin
        mag_d = mag_q;
        dir_d = dir_q;
        tgt_d = tgt_q;
        if (boundary) begin
            unique case (state_q)
                CH_IDLE: if (load && cmd_mag != '0) begin
                    dir_d = cmd_dir;
                    tgt_d = cmd;
                    mag_d = mag_step('0, cmd_mag, STEP);
                end
                CH_RUN: if (reversal) begin
                    tgt_d = cmd;
                    mag_d = '0;
                end else begin
                    tgt_d = {dir_q, tgt_eff[MAG_W-1:0]};
                    mag_d = mag_step(mag_q, tgt_eff[MAG_W-1:0], STEP);
                end
                CH_DEAD: begin
                    tgt_d = tgt_eff;
                    if (tgt_eff[MAG_W-1:0] != '0) begin
                        dir_d = tgt_eff[DIR_BIT];
                        mag_d = mag_step('0, tgt_eff[MAG_W-1:0], STEP);
                    end
                end
                default: mag_d = '0;
            endcase
        end
        pwm = (pwm_cnt < mag_q);
        dir = dir_q;
    end

endmodule

// File: rtl/motor_pwm_ctrl.sv
// Four-channel sign-magnitude PWM controller with period-synchronous updates and link watchdog.
// Optional magnitude ramping is enabled by defining MOTOR_PWM_RAMP_EN.
module motor_pwm_ctrl
    import motor_pkg::*;
#(
    parameter int PRESCALE     = 391,
    parameter int WDOG_PERIODS = 200,
    parameter int RAMP_STEP    = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rdone,
    input  logic [7:0] motor1,
    input  logic [7:0] motor2,
    input  logic [7:0] motor3,
    input  logic [7:0] motor4,
    output logic [3:0] pwm,
    output logic [3:0] dir,
    output logic       fault,
    output logic       pending
);

    localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int WDOG_W  = $clog2(WDOG_PERIODS + 1);
`ifdef MOTOR_PWM_RAMP_EN
    localparam int EFF_STEP = RAMP_STEP;
`else
    // Any step of at least full scale makes every load immediate.
    localparam int EFF_STEP = (RAMP_STEP > MAG_MAX) ? RAMP_STEP : MAG_MAX;
`endif

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [MAG_W-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic               rdone_q, rdone_d;
    logic [3:0][7:0]    shadow_q, shadow_d;
    logic               pending_q, pending_d;
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic               fault_q, fault_d;
    logic               tick, boundary, rise, load, expire;

    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q   <= '0;
            pwm_cnt_q <= '0;
            rdone_q   <= 1'b0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            wdog_q    <= '0;
            fault_q   <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
            rdone_q   <= rdone_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            wdog_q    <= wdog_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        tick      = (presc_q == PRESC_W'(PRESCALE - 1));
        presc_d   = tick ? '0 : presc_q + PRESC_W'(1);
        pwm_cnt_d = pwm_cnt_q;
        if (tick) pwm_cnt_d = (pwm_cnt_q == PWM_TOP) ? '0 : pwm_cnt_q + MAG_W'(1);
        boundary  = tick && (pwm_cnt_q == PWM_TOP);
        rdone_d   = rdone;
        rise      = rdone && !rdone_q;
        load      = boundary && pending_q;
        expire    = boundary && !rise && (wdog_q == WDOG_W'(WDOG_PERIODS - 1));

        shadow_d  = shadow_q;
        pending_d = pending_q;
        wdog_d    = wdog_q;
        fault_d   = fault_q;
        // A rise coinciding with a boundary re-arms pending after the old shadow is loaded.
        if (rise) begin
            shadow_d  = {motor4, motor3, motor2, motor1};
            pending_d = 1'b1;
            wdog_d    = '0;
            fault_d   = 1'b0;
        end else begin
            if (load) pending_d = 1'b0;
            if (boundary && wdog_q != WDOG_W'(WDOG_PERIODS)) wdog_d = wdog_q + WDOG_W'(1);
            if (expire) begin
                fault_d   = 1'b1;
                pending_d = 1'b1;
                for (int i = 0; i < 4; i++) shadow_d[i][MAG_W-1:0] = '0;
            end
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_ch
        motor_pwm_channel #(
            .STEP(EFF_STEP)
        ) u_ch (
            .clock   (clock),
            .reset   (reset),
            .boundary(boundary),
            .load    (load),
            .cmd     (shadow_q[i]),
            .pwm_cnt (pwm_cnt_q),
            .pwm     (pwm[i]),
            .dir     (dir[i])
        );
    end

    assign fault   = fault_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_motor_pwm_ctrl.sv
// Bench for motor_pwm_ctrl: directed vector table, corner sequences and random frames,
// every clock compared against a period-arithmetic reference model.
module tb_motor_pwm_ctrl;

    localparam int P    = 2;
    localparam int W    = 6;
    localparam int RAMP = 4;
    localparam int PER  = P * 127;
`ifdef MOTOR_PWM_RAMP_EN
    localparam int STEP_M = RAMP;
`else
    localparam int STEP_M = 127;
`endif

    typedef struct packed {
        logic [3:0][7:0] cmd;
        logic [3:0][6:0] duty;
        logic [3:0]      dir;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rdone = 1'b0;
    logic [7:0] motor1 = '0, motor2 = '0, motor3 = '0, motor4 = '0;
    logic [3:0] pwm, dir;
    logic       fault, pending;

    motor_pwm_ctrl #(.PRESCALE(P), .WDOG_PERIODS(W), .RAMP_STEP(RAMP)) dut (
        .clock(clock), .reset(reset), .rdone(rdone),
        .motor1(motor1), .motor2(motor2), .motor3(motor3), .motor4(motor4),
        .pwm(pwm), .dir(dir), .fault(fault), .pending(pending)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;
    int hi [4];

    // Reference model state: elapsed clocks since reset give the PWM position directly.
    int m_cyc, m_wd;
    bit m_rd_prev, m_pend, m_fault;
    int m_sh [4];
    int m_mag [4];
    int m_tgtm [4];
    bit m_tgtd [4];
    bit m_dir [4];
    bit m_dead [4];

    function automatic int approach(int cur, int tgt);
        if (tgt > cur + STEP_M) return cur + STEP_M;
        if (tgt < cur - STEP_M) return cur - STEP_M;
        return tgt;
    endfunction

    task automatic model_chan(int c, bit ld);
        int sm;
        bit sd;
        sm = m_sh[c] % 128;
        sd = (m_sh[c] / 128) != 0;
        if (m_dead[c]) begin
            if (ld) begin m_tgtm[c] = sm; m_tgtd[c] = sd; end
            m_dead[c] = 1'b0;
            if (m_tgtm[c] != 0) begin
                m_dir[c] = m_tgtd[c];
                m_mag[c] = approach(0, m_tgtm[c]);
            end
        end else if (m_mag[c] == 0 && m_tgtm[c] == 0) begin
            if (ld && sm != 0) begin
                m_dir[c] = sd; m_tgtm[c] = sm; m_mag[c] = approach(0, sm);
            end
        end else if (ld && sm != 0 && sd != m_dir[c]) begin
            m_dead[c] = 1'b1; m_mag[c] = 0; m_tgtm[c] = sm; m_tgtd[c] = sd;
        end else begin
            if (ld) m_tgtm[c] = sm;
            m_mag[c] = approach(m_mag[c], m_tgtm[c]);
        end
    endtask

    task automatic model_edge();
        int cnt;
        bit bnd, rise, ld, expire;
        if (reset) begin
            m_cyc = 0; m_wd = 0; m_rd_prev = 0; m_pend = 0; m_fault = 0;
            for (int c = 0; c < 4; c++) begin
                m_sh[c] = 0; m_mag[c] = 0; m_tgtm[c] = 0; m_tgtd[c] = 0; m_dir[c] = 0; m_dead[c] = 0;
            end
            return;
        end
        cnt    = (m_cyc / P) % 127;
        bnd    = (m_cyc % P == P - 1) && cnt == 126;
        rise   = rdone && !m_rd_prev;
        m_rd_prev = rdone;
        ld     = bnd && m_pend;
        expire = bnd && !rise && m_wd == W - 1;
        if (bnd) for (int c = 0; c < 4; c++) model_chan(c, ld);
        if (rise) begin
            m_sh[0] = motor1; m_sh[1] = motor2; m_sh[2] = motor3; m_sh[3] = motor4;
            m_pend = 1; m_wd = 0; m_fault = 0;
        end else begin
            if (ld) m_pend = 0;
            if (bnd && m_wd < W) m_wd++;
            if (expire) begin
                m_fault = 1; m_pend = 1;
                for (int c = 0; c < 4; c++) m_sh[c] = (m_sh[c] / 128) * 128;
            end
        end
        m_cyc++;
    endtask

    task automatic check_outputs();
        logic [3:0] ep, ed;
        int cnt;
        cnt = (m_cyc / P) % 127;
        for (int c = 0; c < 4; c++) begin
            ep[c] = (cnt < m_mag[c]);
            ed[c] = m_dir[c];
        end
        n_vec++;
        if ({pwm, dir, fault, pending} !== {ep, ed, m_fault, m_pend}) begin
            n_bad++;
            $display("FAIL cycle t=%0t: got pwm=%b dir=%b fault=%b pending=%b, want pwm=%b dir=%b fault=%b pending=%b",
                     $time, pwm, dir, fault, pending, ep, ed, m_fault, m_pend);
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic cmp(string name, int got, int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic send_frame(input logic [3:0][7:0] cmd);
        motor1 = cmd[0]; motor2 = cmd[1]; motor3 = cmd[2]; motor4 = cmd[3];
        rdone = 1'b1;
        step();
        step();
        rdone = 1'b0;
        step();
    endtask

    // Counts high samples per channel over one period starting at pwm_cnt 0.
    task automatic measure_period();
        while (m_cyc % PER != 0) step();
        for (int c = 0; c < 4; c++) hi[c] = int'(pwm[c]);
        for (int k = 0; k < PER - 1; k++) begin
            step();
            for (int c = 0; c < 4; c++) hi[c] += int'(pwm[c]);
        end
    endtask

    initial begin
        vec_t tbl [6];
        int waited;
        tbl[0] = '{cmd: 32'h0000_0040, duty: {7'd0, 7'd0,  7'd0,   7'd64}, dir: 4'b0000};
        tbl[1] = '{cmd: 32'h0000_7F40, duty: {7'd0, 7'd0,  7'd127, 7'd64}, dir: 4'b0000};
        tbl[2] = '{cmd: 32'h0020_0040, duty: {7'd0, 7'd32, 7'd0,   7'd64}, dir: 4'b0000};
        tbl[3] = '{cmd: 32'h00A0_0040, duty: {7'd0, 7'd32, 7'd0,   7'd64}, dir: 4'b0100};
        tbl[4] = '{cmd: 32'hFF20_85C0, duty: {7'd127, 7'd32, 7'd5, 7'd64}, dir: 4'b1011};
        tbl[5] = '{cmd: 32'h0000_0000, duty: {7'd0, 7'd0,  7'd0,   7'd0},  dir: 4'b1011};

        reset = 1'b1;
        repeat (3) step();
        cmp("reset_state", int'({pwm, dir, fault, pending}), 0);
        reset = 1'b0;

`ifndef MOTOR_PWM_RAMP_EN
        for (int t = 0; t < 6; t++) begin
            send_frame(tbl[t].cmd);
            repeat (3) measure_period();
            for (int c = 0; c < 4; c++)
                cmp($sformatf("tbl%0d_duty_ch%0d", t, c + 1), hi[c], int'(tbl[t].duty[c]) * P);
            cmp($sformatf("tbl%0d_dir", t), int'(dir), int'(tbl[t].dir));
        end

        // Rise landing exactly on a boundary: old shadow applies, new one waits a period.
        while (m_cyc % PER != 10) step();
        send_frame(32'h0000_0010);
        motor1 = 8'h30;
        while (m_cyc % PER != PER - 1) step();
        rdone = 1'b1;
        step();
        cmp("rise_at_boundary_pending", int'(pending), 1);
        measure_period();
        cmp("rise_at_boundary_old_duty", hi[0], 16 * P);
        rdone = 1'b0;
        measure_period();
        cmp("rise_at_boundary_new_duty", hi[0], 48 * P);

        // Watchdog expiry and recovery.
        send_frame(32'h0000_0050);
        waited = 0;
        while (fault !== 1'b1 && waited < (W + 3) * PER) begin
            step();
            waited++;
        end
        cmp("wdog_fault_set", int'(fault), 1);
        measure_period();
        cmp("wdog_last_run_duty", hi[0], 80 * P);
        measure_period();
        cmp("wdog_stopped_duty", hi[0], 0);
        send_frame(32'h0000_0030);
        cmp("wdog_fault_cleared", int'(fault), 0);
        repeat (3) measure_period();
        cmp("wdog_recover_duty", hi[0], 48 * P);
`else
        while (m_cyc % PER != 10) step();
        send_frame(32'h0000_0010);
        for (int k = 1; k <= 4; k++) begin
            measure_period();
            cmp($sformatf("ramp_period%0d_duty", k), hi[0], 4 * k * P);
        end
`endif

        for (int it = 0; it < 30; it++) begin
            int gap;
            gap = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1200, 1800))
                                               : int'($urandom_range(0, 500));
            repeat (gap) step();
            if (it == 15) begin
                reset = 1'b1;
                step();
                step();
                reset = 1'b0;
            end
            motor1 = 8'($urandom_range(0, 255));
            motor2 = 8'($urandom_range(0, 255));
            motor3 = 8'($urandom_range(0, 255));
            motor4 = 8'($urandom_range(0, 255));
            rdone = 1'b1;
            repeat ($urandom_range(1, 4)) step();
            rdone = 1'b0;
            step();
        end
        repeat (3 * PER) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
